// File: rtl/fixed_point_pkg.sv
// Shared fixed-point widths, accumulator width helper and datapath typedefs
// used by the MAC engine and the rounding stage.
package fixed_point_pkg;

  localparam int unsigned IL_DEF = 4;
  localparam int unsigned FL_DEF = 16;

  // Accumulator width: full product plus 4 guard bits.
  function automatic int unsigned acc_w(input int unsigned il, input int unsigned fl);
    return 4 + 2 * (il + fl);
  endfunction

  localparam int unsigned OPERAND_W = IL_DEF + FL_DEF;
  localparam int unsigned PRODUCT_W = 2 * OPERAND_W;
  localparam int unsigned ACC_W     = acc_w(IL_DEF, FL_DEF);

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic signed [PRODUCT_W-1:0] product_t;
  typedef logic signed [ACC_W-1:0]     acc_t;

endpackage

// File: rtl/fxp_multiplier.sv
// Registered signed IL.FL x IL.FL multiplier (S1) with hold enable; the
// product keeps all 2*FL fraction bits.
module fxp_multiplier
  import fixed_point_pkg::*;
#(
  parameter int unsigned OP_W = OPERAND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              last,
  output logic [2*OP_W-1:0] p_q,
  output logic              p_valid,
  output logic              p_last
);

  localparam int unsigned PROD_W = 2 * OP_W;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;

  // Operands sign-extended to product width so the multiply is exact.
  assign a_ext = PROD_W'($signed(a));
  assign b_ext = PROD_W'($signed(b));
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (en) begin
      p_valid <= load;
      p_last  <= load & last;
      if (load) p_q <= prod;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Signed fixed-point multiply-accumulate engine emitting one wide sum per
// in_last-terminated vector. Define ACC_SAT_EN for saturating accumulation.
module mac_accumulator
  import fixed_point_pkg::*;
#(
  parameter int unsigned IL      = IL_DEF,
  parameter int unsigned FL      = FL_DEF,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IL+FL-1:0]               a,
  input  logic [IL+FL-1:0]               b,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [acc_w(IL, FL)-1:0]       acc,
  output logic [$clog2(MAX_LEN+2)-1:0]   out_count,
  output logic                           len_err,
  output logic                           sat
);

  localparam int unsigned OP_W   = IL + FL;
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned SUM_W  = acc_w(IL, FL);
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 2);

  logic              stall;
  logic              step;
  logic [PROD_W-1:0] p_q;
  logic              p_valid;
  logic              p_last;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  prod_ext;
  logic [SUM_W-1:0]  acc_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_next;
  logic              err_q;
  logic              err_next;

  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign step = p_valid & ~stall;

  fxp_multiplier #(.OP_W(OP_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .en      (~stall),
    .load    (in_valid & in_ready),
    .a       (a),
    .b       (b),
    .last    (in_last),
    .p_q     (p_q),
    .p_valid (p_valid),
    .p_last  (p_last)
  );

  assign prod_ext = {{(SUM_W-PROD_W){p_q[PROD_W-1]}}, p_q};
  assign cnt_next = (cnt_q == CNT_W'(MAX_LEN + 1)) ? cnt_q : cnt_q + CNT_W'(1);
  assign err_next = err_q | (cnt_next > CNT_W'(MAX_LEN));

`ifdef ACC_SAT_EN
  logic [SUM_W:0] wide;
  logic           clamp;
  logic           sat_q;
  logic           sat_next;

  // One extra bit exposes signed overflow; clamp to the nearest bound.
  always_comb begin
    wide     = {sum_q[SUM_W-1], sum_q} + {prod_ext[SUM_W-1], prod_ext};
    clamp    = wide[SUM_W] ^ wide[SUM_W-1];
    acc_next = wide[SUM_W-1:0];
    if (clamp) acc_next = wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}}
                                      : {1'b0, {(SUM_W-1){1'b1}}};
    sat_next = sat_q | clamp;
  end
`else
  assign acc_next = sum_q + prod_ext;
  assign sat      = 1'b0;
`endif

  // S2 running state; cleared after the last term so vectors never mix.
  always_ff @(posedge clk) begin
    if (reset || (step && p_last)) begin
      sum_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
`ifdef ACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (step) begin
      sum_q <= acc_next;
      cnt_q <= cnt_next;
      err_q <= err_next;
`ifdef ACC_SAT_EN
      sat_q <= sat_next;
`endif
    end
  end

  // Result register: a new load wins over a simultaneous drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      acc       <= '0;
      out_count <= '0;
      len_err   <= 1'b0;
`ifdef ACC_SAT_EN
      sat       <= 1'b0;
`endif
    end else if (step && p_last) begin
      out_valid <= 1'b1;
      acc       <= acc_next;
      out_count <= cnt_next;
      len_err   <= err_next;
`ifdef ACC_SAT_EN
      sat       <= sat_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Signed fixed-point multiply-accumulate engine that produces the wide dot-product value consumed by the stochastic rounding stage. Accepts a stream of IL.FL operand pairs under valid/ready and forms exact products with 2·FL fraction bits. Accumulates them into a (4+2·(IL+FL))-bit sum and emits one result per `in_last`-terminated vector. Sits between the operand buffers and the rounding/requantization stage of the attention and feed-forward datapaths.

## Interface
- `IL`, 4, integer bits of each operand, including sign
- `FL`, 16, fraction bits of each operand
- `MAX_LEN`, 16, maximum terms per vector before `len_err`; the 4 guard bits cover 16 terms at full magnitude
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block accepts operand pair
- `a`, `b`  in  IL+FL each  signed operands, binary point at FL
- `in_last`  in  1  final term of the current vector
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `acc`  out  ACC_W = 4+2·(IL+FL)  signed sum, binary point at 2·FL
- `out_count`  out  $clog2(MAX_LEN+2)  terms in the vector, saturating at MAX_LEN+1
- `len_err`  out  1  vector exceeded MAX_LEN terms
- `sat`  out  1  accumulator clamped; constant 0 when `ACC_SAT_EN` is undefined

## Operation
- Pipeline: S1 product register (`p_q`, `p_valid`, `p_last`); S2 running accumulator (`sum_q`, `cnt_q`, `err_q`, `sat_q`); result register (`acc`, `out_count`, `len_err`, `sat`, `out_valid`).
- `stall = out_valid & ~out_ready`; `in_ready = ~stall`. When `stall` is high, S1 and S2 hold.
- Transfer occurs on `in_valid & in_ready`. S1 loads `p_q = a*b` (full 2·(IL+FL)-bit signed product) and sets `p_valid = 1`. With no transfer and no stall, `p_valid` clears.
- S2, when `p_valid & ~stall`:
  - `next = sum_q + sext(p_q)` at ACC_W.
  - `cnt_next = min(cnt_q+1, MAX_LEN+1)`.
  - `err` sets when `cnt_next > MAX_LEN`.
- If `p_last`: the result register loads `next`, `cnt_next`, `err` and the sat flag, and `out_valid` is set. `sum_q`, `cnt_q`, `err_q` and `sat_q` clear so the next vector starts at zero.
- If not `p_last`: `sum_q` takes `next` and the remaining S2 state updates.
- `out_valid` clears on `out_ready` unless a new result loads in the same cycle. A simultaneous load and drain keeps `out_valid` high with the new data.
- Single-term vector: `in_last` is set on the first pair; the result is that pair's product.
- Reset mid-vector: the partial sum and any held result are discarded with no output.
- States are implicit: EMPTY (`sum_q` = 0, `cnt_q` = 0), ACCUM (`cnt_q` > 0), HELD (`stall`).

## Timing
- Reset values: `in_ready` 1, `out_valid` 0, `acc` 0, `out_count` 0, `len_err` 0, `sat` 0; S1 and S2 are cleared.
- Latency: a pair with `in_last` accepted at cycle t produces `out_valid` at t+2.
- Throughput: one pair per cycle with no bubbles between vectors while `out_ready` = 1.
- `acc`, `out_count`, `len_err` and `sat` are stable while `out_valid & ~out_ready`.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_valid`.

## Configuration
- `ACC_SAT_EN`:
  - Defined: S2 addition saturates at the ACC_W signed bounds, `0x7FF…F` and `0x800…0`. `sat` is set for the vector once any clamp occurs and is sticky until the result is loaded.
  - Undefined: two's-complement wrap, and `sat` is tied to 0.

## Structure
- `fixed_point_pkg` holds the `IL`/`FL` defaults, an `ACC_W` width function, and the operand, product and accumulator typedefs shared with the rounding stage.
- One sub-module, `fxp_multiplier`, is the registered signed product (S1) with its own hold enable.

## Test plan
- IL=4, FL=16: four pairs with a=b=0x10000 (1.0), `in_last` on the 4th, and `out_ready` held at 1 → `out_valid` 2 cycles after the last pair, `acc` = 0x004_0000_0000, `out_count` = 4, `len_err` = 0.
- Single pair a=0xF0000 (−1.0), b=0x08000 (0.5), `in_last` = 1 → `acc` = 0xFFF_8000_0000, `out_count` = 1.
- Two back-to-back vectors {1.0·1.0}, {1.0·1.0, 1.0·1.0} → `out_valid` high on consecutive results: first `acc` 0x001_0000_0000, second 0x002_0000_0000, with no residue carried between vectors.
- Backpressure: `out_ready` = 0 for 5 cycles while a result is held → `in_ready` = 0, `acc` held constant, no operand lost. Release → the next vector's result is correct.
- 32 pairs of 0x80000·0x80000 (−8·−8 = 2^38):
  - `len_err` = 1 and `out_count` = 17.
  - `ACC_SAT_EN` undefined: `acc` = 0x800_0000_0000 (wrapped), `sat` = 0.
  - `ACC_SAT_EN` defined: `acc` = 0x7FF_FFFF_FFFF, `sat` = 1.
- Assert `reset` after 3 terms of a vector: all outputs return to reset values the next cycle. A new 1-term vector then yields only its own product.
